// File: rtl/tt_subtract_pkg.sv
// tt_subtract_pkg: shared width, state encoding and pin bit indices for the serial subtractor
package tt_subtract_pkg;
    localparam int WIDTH  = 8;
    localparam int LOAD_A = 0;
    localparam int LOAD_B = 1;
    localparam int START  = 2;
    localparam int BUSY   = 4;
    localparam int DONE   = 5;
    localparam int BORROW = 6;
    localparam int ZERO   = 7;
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
endpackage

// File: rtl/serial_sub_cell.sv
// serial_sub_cell: 1-bit full subtractor with its borrow-in flop
module serial_sub_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    input  logic a,
    input  logic b,
    output logic d,
    output logic bout,
    output logic bin
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
    always_ff @(posedge clk)
        if (!rst_n)   bin <= 1'b0;
        else if (clr) bin <= 1'b0;
        else if (en)  bin <= bout;
endmodule

// File: rtl/tt_um_subtract_serial.sv
// tt_um_subtract_serial: bit-serial 8-bit A-B, LSB first, one bit per enabled cycle
module tt_um_subtract_serial
    import tt_subtract_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    state_t state, state_nxt;
    logic [WIDTH-1:0] reg_a, reg_b, sh_a, sh_b, diff, uo_q;
    logic [WIDTH-2:0] res;
    logic [$clog2(WIDTH)-1:0] cnt;
    logic done, borrow, zero, d, bout, bin, idle, run, go, last;
    logic unused;
    assign unused = &{1'b0, uio_in[7:3]};
    assign idle = state == S_IDLE;
    assign run  = state == S_RUN;
    assign go   = ena & idle & uio_in[START];
    assign last = cnt == ($clog2(WIDTH))'(WIDTH - 1);
    assign diff = {d, res};
    serial_sub_cell u_cell (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ena & run),
        .clr  (go),
        .a    (sh_a[0]),
        .b    (sh_b[0]),
        .d    (d),
        .bout (bout),
        .bin  (bin)
    );
    always_ff @(posedge clk)
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    always_comb begin
        state_nxt = !ena             ? state  :
                    go               ? S_RUN  :
                    (run && last)    ? S_DONE :
                    state == S_DONE  ? S_IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            reg_a  <= '0;
            reg_b  <= '0;
            sh_a   <= '0;
            sh_b   <= '0;
            res    <= '0;
            cnt    <= '0;
            uo_q   <= '0;
            done   <= 1'b0;
            borrow <= 1'b0;
            zero   <= 1'b1;
        end else if (ena) begin
            if (idle && uio_in[LOAD_A]) reg_a <= ui_in;
            if (idle && uio_in[LOAD_B]) reg_b <= ui_in;
            // start copies the operands latched before this edge, so a same-cycle load waits
            if (go) begin
                sh_a <= reg_a;
                sh_b <= reg_b;
                cnt  <= '0;
                done <= 1'b0;
            end
            if (run) begin
                sh_a <= sh_a >> 1;
                sh_b <= sh_b >> 1;
                res  <= diff[WIDTH-1:1];
                cnt  <= cnt + 1'b1;
                if (last) begin
                    uo_q   <= diff;
                    borrow <= bout;
                    zero   <= diff == '0;
                    done   <= 1'b1;
                end
            end
        end
    end
    assign uo_out  = uo_q;
    assign uio_out = {zero, borrow, done, !idle, 4'b0000};
    assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_subtract_serial.sv
// tb_tt_um_subtract_serial: vector table, corner sequences and random ops against an arithmetic model
module tb_tt_um_subtract_serial;
    logic clk = 1'b0, rst_n = 1'b0, ena = 1'b1;
    logic [7:0] ui_in = 8'h00, uio_in = 8'h00;
    logic [7:0] uo_out, uio_out, uio_oe;
    int n_chk = 0, n_pass = 0;

    tt_um_subtract_serial dut (
        .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in),
        .uio_in(uio_in), .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a, b;
        bit         both;
        logic [7:0] diff;
        bit         borrow, zero;
    } vec_t;
    vec_t tbl[7];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic load(input logic [7:0] a, input logic [7:0] b, input bit both);
        if (both) begin
            ui_in = a; uio_in = 8'h03; @(negedge clk);
        end else begin
            ui_in = a; uio_in = 8'h01; @(negedge clk);
            ui_in = b; uio_in = 8'h02; @(negedge clk);
        end
        uio_in = 8'h00;
    endtask

    task automatic start();
        uio_in = 8'h04; @(negedge clk);
        uio_in = 8'h00;
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        while (uio_out[4] && cyc < 40) begin
            cyc++;
            @(negedge clk);
        end
    endtask

    function automatic logic [7:0] status(input bit z, input bit br, input bit dn);
        return {z, br, dn, 1'b0, 4'h0};
    endfunction

    task automatic check_result(input string name, input logic [7:0] diff, input bit br, input bit z);
        chk({name, " uo_out"}, uo_out, diff);
        chk({name, " status"}, uio_out, status(z, br, 1'b1));
    endtask

    initial begin
        int cyc;
        logic [7:0] a, b, prev;
        tbl[0] = '{8'd99,  8'd20,  1'b0, 8'd79,  1'b0, 1'b0};
        tbl[1] = '{8'd20,  8'd99,  1'b0, 8'd177, 1'b1, 1'b0};
        tbl[2] = '{8'd50,  8'd50,  1'b1, 8'd0,   1'b0, 1'b1};
        tbl[3] = '{8'd0,   8'd1,   1'b0, 8'd255, 1'b1, 1'b0};
        tbl[4] = '{8'd255, 8'd0,   1'b0, 8'd255, 1'b0, 1'b0};
        tbl[5] = '{8'd0,   8'd255, 1'b0, 8'd1,   1'b1, 1'b0};
        tbl[6] = '{8'd128, 8'd127, 1'b0, 8'd1,   1'b0, 1'b0};

        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        chk("reset uo_out", uo_out, 0);
        chk("reset status", uio_out, 8'h80);
        chk("reset oe", uio_oe, 8'hF0);

        for (int i = 0; i < 7; i++) begin
            load(tbl[i].a, tbl[i].b, tbl[i].both);
            start();
            chk($sformatf("vec%0d done cleared", i), uio_out[5], 0);
            wait_idle(cyc);
            chk($sformatf("vec%0d busy cycles", i), cyc, 9);
            check_result($sformatf("vec%0d", i), tbl[i].diff, tbl[i].borrow, tbl[i].zero);
        end

        repeat (4) @(negedge clk);
        chk("done sticky", uio_out[5], 1);

        ena = 1'b0;
        ui_in = 8'd77; uio_in = 8'h07; @(negedge clk);
        uio_in = 8'h00; ena = 1'b1;
        chk("ena low start ignored", uio_out[4], 0);
        start();
        wait_idle(cyc);
        check_result("ena low load ignored", 8'd1, 1'b0, 1'b0);

        load(8'd8, 8'd6, 1'b0);
        start();
        prev = uo_out;
        cyc = 0;
        while (uio_out[4] && cyc < 40) begin
            uio_in = (cyc == 3) ? 8'h07 : 8'h00;
            ui_in = 8'd200;
            if (cyc == 5) chk("uo_out holds in RUN", uo_out, prev);
            cyc++;
            @(negedge clk);
        end
        uio_in = 8'h00;
        chk("ignored start busy cycles", cyc, 9);
        check_result("ignored start", 8'd2, 1'b0, 1'b0);
        start();
        wait_idle(cyc);
        check_result("ignored load not applied", 8'd2, 1'b0, 1'b0);

        load(8'd5, 8'd3, 1'b0);
        ui_in = 8'd100; uio_in = 8'h07; @(negedge clk);
        uio_in = 8'h00;
        wait_idle(cyc);
        check_result("start uses old operands", 8'd2, 1'b0, 1'b0);
        start();
        wait_idle(cyc);
        check_result("load with start applies next", 8'd0, 1'b0, 1'b1);

        load(8'd112, 8'd15, 1'b0);
        start();
        wait_idle(cyc);
        check_result("pre-abort", 8'd97, 1'b0, 1'b0);
        load(8'd15, 8'd112, 1'b0);
        start();
        cyc = 0;
        while (uio_out[4] && cyc < 40) begin
            rst_n = !(cyc == 4);
            cyc++;
            @(negedge clk);
        end
        rst_n = 1'b1;
        chk("abort cycles", cyc, 5);
        chk("abort uo_out", uo_out, 0);
        chk("abort status", uio_out, 8'h80);
        load(8'd15, 8'd112, 1'b0);
        start();
        wait_idle(cyc);
        check_result("rerun after abort", 8'd159, 1'b1, 1'b0);

        load(8'd200, 8'd73, 1'b0);
        start();
        cyc = 0;
        while (uio_out[4] && cyc < 40) begin
            ena = !(cyc >= 3 && cyc < 8);
            chk("oe during stall", uio_oe, 8'hF0);
            cyc++;
            @(negedge clk);
        end
        ena = 1'b1;
        chk("stall busy cycles", cyc, 14);
        check_result("stall", 8'd127, 1'b0, 1'b0);

        for (int i = 0; i < 20; i++) begin
            a = 8'($urandom_range(0, 255));
            b = (i % 5 == 0) ? a : 8'($urandom_range(0, 255));
            load(a, b, 1'b0);
            start();
            wait_idle(cyc);
            check_result($sformatf("rand%0d %0d-%0d", i, a, b), 8'((int'(a) - int'(b) + 256) % 256),
                         a < b, a == b);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tt_um_subtract_serial.md
TT_UM_SUBTRACT_SERIAL -- requirements
Module: tt_um_subtract_serial

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 ena  input  1  design-selected enable; when low, all strobes are ignored and state holds.
REQ-005 ui_in  input  8  data byte for operand loads.
REQ-006 uio_in  input  8  control: [0] load_a, [1] load_b, [2] start; [7:3] ignored.
REQ-007 uo_out  output  8  last completed difference A-B, unsigned modulo 256.
REQ-008 uio_out  output  8  status: [4] busy, [5] done, [6] borrow, [7] zero; [3:0] driven 0.
REQ-009 uio_oe  output  8  constant 8'hF0 (bits 7:4 outputs, 3:0 inputs).

Function
REQ-010 FSM states SHALL be IDLE, RUN, DONE; busy = (state != IDLE).
REQ-011 In IDLE with ena=1, load_a SHALL latch ui_in into reg_a, and load_b SHALL latch ui_in into reg_b; both high latches ui_in into both.
REQ-012 In IDLE with ena=1, start SHALL copy reg_a/reg_b into shift registers, clear borrow-in and the bit counter, clear done, and enter RUN.
REQ-013 Load and start in the same cycle: start SHALL use the previously latched operands; the load takes effect for the next operation.
REQ-014 In RUN, each cycle SHALL process one bit LSB-first: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin); d shifts into the result MSB, operands shift right.
REQ-015 RUN SHALL last exactly 8 cycles (counter 0..7); on the 8th edge: uo_out <= result, borrow <= final bout, zero <= (result==0), done <= 1, state <= DONE.
REQ-016 DONE SHALL last one cycle and then return to IDLE unconditionally.
REQ-017 Latency: start sampled at edge N -> uo_out/flags valid after edge N+8; busy high after edges N..N+8; IDLE after edge N+9.
REQ-018 uo_out, borrow and zero SHALL hold the previous result during RUN and change only at completion.
REQ-019 done SHALL be sticky: it stays high until the next accepted start or reset.
REQ-020 start, load_a and load_b SHALL be ignored in RUN and DONE; they are not queued.
REQ-021 With ena=0, the FSM, counter and shift registers SHALL freeze; operation resumes where it stopped when ena returns high.
REQ-022 Result arithmetic SHALL be 8-bit unsigned; borrow=1 exactly when A<B.

Reset
REQ-023 With rst_n=0 at a rising edge: state=IDLE, reg_a=reg_b=0, shift registers=0, counter=0, uo_out=0, busy=done=borrow=0, zero=1.
REQ-024 Reset during RUN SHALL abort the operation without publishing a partial result; reset has priority over all strobes and ena.

Structure
REQ-025 Shared package tt_subtract_pkg SHALL hold the state enum, WIDTH=8, the control-bit indices (LOAD_A=0, LOAD_B=1, START=2) and the status-bit indices (BUSY=4, DONE=5, BORROW=6, ZERO=7).
REQ-026 One sub-module, serial_sub_cell, SHALL implement the 1-bit full subtractor and the borrow flop, including the clear input; the top level holds the FSM, counter and registers.

Verification
REQ-027 Load A=99, B=20, start -> after 8 cycles uo_out=79, borrow=0, zero=0, done=1.
REQ-028 Load A=20, B=99, start -> uo_out=177 (0xB1), borrow=1, zero=0.
REQ-029 Load A=B=50 (single cycle with load_a and load_b both high), start -> uo_out=0, zero=1, borrow=0; also A=0, B=1 -> uo_out=255, borrow=1.
REQ-030 Start A=8, B=6; at cycle 3 of RUN pulse start with new loads -> ignored, result=2, busy exactly 9 cycles, then IDLE.
REQ-031 Complete A=112, B=15 (uo_out=97); start A=15, B=112, assert rst_n=0 at RUN cycle 4 -> uo_out=0, flags cleared, zero=1, IDLE; a rerun then gives 159, borrow=1.
REQ-032 Hold ena=0 for 5 cycles mid-RUN -> completion delayed by exactly 5 cycles, correct result; uio_oe=8'hF0 throughout.
